// File: rtl/timer_arbiter.sv
// Round-robin arbiter that lends one shared up/down threshold counter to N_REQ requesters,
// runs it to the terminal count and returns a one-cycle done pulse to the winner.
module timer_arbiter #(
    parameter int N_REQ = 4,
    parameter int CW    = 4
) (
    input  logic                clk,
    input  logic                n_reset,
    input  logic                enable,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*CW-1:0] req_th,
    input  logic [N_REQ-1:0]    req_dn_up,
    output logic [N_REQ-1:0]    gnt,
    output logic [N_REQ-1:0]    done,
    output logic                busy,
    output logic [CW-1:0]       cntout,
    output logic                timeout
);

    localparam int IW = $clog2(N_REQ);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t        state;
    logic [IW-1:0] last_idx;
    logic [IW-1:0] cur_idx;
    logic [IW-1:0] win_idx;
    logic          win_found;
    logic [CW-1:0] th_q;
    logic          up_q;
    logic [CW-1:0] terminal;

    // Search for the first active request starting just after the last winner.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!win_found && req[(int'(last_idx) + 1 + k) % N_REQ]) begin
                win_found = 1'b1;
                win_idx   = IW'((int'(last_idx) + 1 + k) % N_REQ);
            end
        end
    end

    assign terminal = up_q ? th_q : '0;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state    <= IDLE;
            last_idx <= IW'(N_REQ - 1);
            cur_idx  <= '0;
            th_q     <= '0;
            up_q     <= 1'b0;
            gnt      <= '0;
            done     <= '0;
            busy     <= 1'b0;
            cntout   <= '0;
            timeout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        state    <= LOAD;
                        last_idx <= win_idx;
                        cur_idx  <= win_idx;
                        th_q     <= req_th[int'(win_idx)*CW +: CW];
                        up_q     <= req_dn_up[win_idx];
                        gnt      <= N_REQ'(1) << win_idx;
                        busy     <= 1'b1;
                    end
                end
                LOAD: begin
                    if (!req[cur_idx]) begin
                        state <= IDLE;
                        gnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        state  <= RUN;
                        cntout <= up_q ? '0 : th_q;
                    end
                end
                RUN: begin
                    // Withdrawal wins over terminal detection; terminal is checked before counting.
                    if (!req[cur_idx]) begin
                        state <= IDLE;
                        gnt   <= '0;
                        busy  <= 1'b0;
                    end else if (cntout == terminal) begin
                        state   <= DONE;
                        done    <= gnt;
                        timeout <= 1'b1;
                    end else if (enable) begin
                        cntout <= up_q ? cntout + 1'b1 : cntout - 1'b1;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    gnt     <= '0;
                    done    <= '0;
                    busy    <= 1'b0;
                    timeout <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_timer_arbiter.sv
// Self-checking bench for timer_arbiter: a table of single-request vectors plus hand-written
// round-robin, withdrawal, parameter-latch and reset sequences; done pulses go through a scoreboard.
module tb_timer_arbiter;

    logic        clk = 1'b0;
    logic        n_reset = 1'b1;
    logic        enable = 1'b1;
    logic [3:0]  req = '0;
    logic [15:0] req_th = '0;
    logic [3:0]  req_dn_up = '0;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        busy;
    logic [3:0]  cntout;
    logic        timeout;

    int checks = 0;
    int passed = 0;
    int cycle = 0;
    bit mon_en = 1'b0;

    typedef struct {
        logic [3:0] mask;
        int         at_cycle;
        logic [3:0] final_cnt;
    } sb_entry_t;

    typedef struct {
        int         idx;
        logic [3:0] th;
        logic       up;
        int         gaps;
        logic [3:0] exp_gnt;
        logic [3:0] exp_start;
        int         exp_lat;
        logic [3:0] exp_final;
    } vec_t;

    sb_entry_t sb[$];
    sb_entry_t mon_e;
    vec_t      vectors[6];

    timer_arbiter #(.N_REQ(4), .CW(4)) dut (
        .clk(clk),
        .n_reset(n_reset),
        .enable(enable),
        .req(req),
        .req_th(req_th),
        .req_dn_up(req_dn_up),
        .gnt(gnt),
        .done(done),
        .busy(busy),
        .cntout(cntout),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (mon_en && done !== 4'b0000) begin
            if (sb.size() == 0) begin
                checks++;
                $display("[TB] FAIL unexpected_done: got done=%b expected no done", done);
            end else begin
                mon_e = sb.pop_front();
                check_output("done_mask", done, mon_e.mask);
                check_output("done_cycle", cycle, mon_e.at_cycle);
                check_output("done_timeout", timeout, 1);
                check_output("done_cntout", cntout, mon_e.final_cnt);
            end
        end
    end

    task automatic wait_cycle(input int target);
        while (cycle < target) @(negedge clk);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (done === 4'b0000 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (done === 4'b0000) begin
            checks++;
            $display("[TB] FAIL %s: got no done in %0d cycles expected a done pulse", name, n);
        end
    endtask

    task automatic finish_service(input string name);
        wait_done(name);
        req = '0;
        @(negedge clk);
        check_output({name, "_gnt_clr"}, gnt, 0);
        check_output({name, "_busy_clr"}, busy, 0);
        @(negedge clk);
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        #2 n_reset = 1'b0;
        #1;
        check_output({name, "_gnt"}, gnt, 0);
        check_output({name, "_done"}, done, 0);
        check_output({name, "_busy"}, busy, 0);
        check_output({name, "_cntout"}, cntout, 0);
        check_output({name, "_timeout"}, timeout, 0);
        @(negedge clk);
        n_reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic apply_stimulus(input vec_t v, input int i);
        int e0;
        req_th[v.idx*4 +: 4] = v.th;
        req_dn_up[v.idx] = v.up;
        req = 4'b0001 << v.idx;
        enable = 1'b1;
        e0 = cycle + 1;
        sb.push_back('{v.exp_gnt, e0 + v.exp_lat, v.exp_final});
        wait_cycle(e0);
        check_output($sformatf("v%0d_gnt", i), gnt, v.exp_gnt);
        check_output($sformatf("v%0d_busy", i), busy, 1);
        wait_cycle(e0 + 1);
        check_output($sformatf("v%0d_start", i), cntout, v.exp_start);
        if (v.gaps > 0) begin
            wait_cycle(e0 + 2);
            enable = 1'b0;
            repeat (v.gaps) @(negedge clk);
            enable = 1'b1;
        end
        finish_service($sformatf("v%0d", i));
    endtask

    initial begin
        int e0;
        vectors[0] = '{1, 4'd5,  1'b1, 0, 4'b0010, 4'd0,  7,  4'd5};
        vectors[1] = '{2, 4'd12, 1'b0, 3, 4'b0100, 4'd12, 17, 4'd0};
        vectors[2] = '{0, 4'd0,  1'b1, 0, 4'b0001, 4'd0,  2,  4'd0};
        vectors[3] = '{3, 4'd0,  1'b0, 0, 4'b1000, 4'd0,  2,  4'd0};
        vectors[4] = '{3, 4'd15, 1'b1, 1, 4'b1000, 4'd0,  18, 4'd15};
        vectors[5] = '{0, 4'd7,  1'b0, 2, 4'b0001, 4'd7,  11, 4'd0};

        repeat (2) @(negedge clk);
        do_reset("reset");
        mon_en = 1'b1;

        for (int i = 0; i < 6; i++) apply_stimulus(vectors[i], i);

        // Reset in the middle of a run: no done, and the pointer restarts at requester 0.
        req_th[2*4 +: 4] = 4'd10;
        req_dn_up = 4'b1111;
        req = 4'b0100;
        e0 = cycle + 1;
        wait_cycle(e0 + 3);
        check_output("midrun_busy", busy, 1);
        #2 n_reset = 1'b0;
        #1;
        check_output("midrun_rst_gnt", gnt, 0);
        check_output("midrun_rst_busy", busy, 0);
        check_output("midrun_rst_cntout", cntout, 0);
        check_output("midrun_rst_done", done, 0);
        check_output("midrun_rst_timeout", timeout, 0);
        req_th[1*4 +: 4] = 4'd3;
        req = 4'b0110;
        @(negedge clk);
        n_reset = 1'b1;
        e0 = cycle + 1;
        sb.push_back('{4'b0010, e0 + 5, 4'd3});
        wait_cycle(e0);
        check_output("after_rst_gnt", gnt, 4'b0010);
        finish_service("after_rst");

        // Round robin with every requester held and zero thresholds.
        do_reset("rr_reset");
        req_th = '0;
        req_dn_up = 4'b1111;
        req = 4'b1111;
        e0 = cycle + 1;
        for (int k = 0; k < 5; k++) sb.push_back('{4'b0001 << (k % 4), e0 + 4*k + 2, 4'd0});
        for (int k = 0; k < 5; k++) begin
            wait_cycle(e0 + 4*k);
            check_output($sformatf("rr_gnt%0d", k), gnt, 4'b0001 << (k % 4));
        end
        wait_cycle(e0 + 18);
        req = '0;
        wait_cycle(e0 + 20);
        check_output("rr_idle_gnt", gnt, 0);
        @(negedge clk);

        // Withdrawal of requester 2 at count 3, requester 3 waiting.
        req_th[2*4 +: 4] = 4'd8;
        req_th[3*4 +: 4] = 4'd2;
        req_dn_up = 4'b1111;
        req = 4'b1100;
        e0 = cycle + 1;
        wait_cycle(e0);
        check_output("wd_gnt2", gnt, 4'b0100);
        wait_cycle(e0 + 4);
        check_output("wd_cnt3", cntout, 3);
        req = 4'b1000;
        wait_cycle(e0 + 5);
        check_output("wd_gnt_clr", gnt, 0);
        check_output("wd_busy_clr", busy, 0);
        sb.push_back('{4'b1000, e0 + 10, 4'd2});
        wait_cycle(e0 + 6);
        check_output("wd_gnt3", gnt, 4'b1000);
        finish_service("wd");

        // Threshold and direction changed mid-run must not affect the running interval.
        req_th[1*4 +: 4] = 4'd5;
        req_dn_up = 4'b1111;
        req = 4'b0010;
        e0 = cycle + 1;
        sb.push_back('{4'b0010, e0 + 7, 4'd5});
        wait_cycle(e0 + 2);
        req_th[1*4 +: 4] = 4'd9;
        req_dn_up = 4'b0000;
        wait_cycle(e0 + 4);
        check_output("latch_cnt", cntout, 3);
        finish_service("latch");

        check_output("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/timer_arbiter.md
# timer_arbiter

Round-robin scheduler that shares one 4-bit up/down threshold counter among several requesters. Each requester asks for a timed interval with its own threshold and direction. The block grants the counter to one requester at a time, loads it, runs it to the terminal count, and returns a one-cycle `done` pulse to the winner. It sits between the control agents and the shared counter resource, and it contains the counter itself.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters (2..8).
- `CW`, default 4: counter and threshold width.

Ports:
- `clk`  in  1: single clock, rising-edge.
- `n_reset`  in  1: asynchronous, active-low reset.
- `enable`  in  1: count enable; gates counting in RUN only.
- `req`  in  N_REQ: per-requester request level; held until `done` or withdrawn.
- `req_th`  in  N_REQ*CW: thresholds; requester i uses bits `[i*CW +: CW]`.
- `req_dn_up`  in  N_REQ: direction per requester; 1 = count up, 0 = count down.
- `gnt`  out  N_REQ: one-hot grant, or all zero.
- `done`  out  N_REQ: one-cycle completion pulse to the granted requester.
- `busy`  out  1: high in LOAD, RUN and DONE.
- `cntout`  out  CW: current counter value.
- `timeout`  out  1: one-cycle pulse, coincident with any `done` bit.

## Operation
- States: IDLE, LOAD, RUN, DONE. All outputs are registered.
- **Reset (async):** state = IDLE; `gnt`, `done`, `busy`, `timeout` = 0; `cntout` = 0. The round-robin pointer is set so that requester 0 has highest priority first.
- **IDLE:** if any `req` is high, pick the winner. The search starts at index (last granted + 1) mod N_REQ and takes the first high `req`. Latch the winner's `req_th` and `req_dn_up`, set `gnt` one-hot, go to LOAD, and update the pointer to the winner. If no `req` is high, stay in IDLE.
- **LOAD:** `cntout` <= 0 for up mode, or the latched threshold for down mode. Go to RUN.
- **RUN:**
  - The terminal value is the threshold in up mode and 0 in down mode.
  - If `cntout` == terminal: go to DONE, with `done[i]` = 1 and `timeout` = 1 on the next cycle.
  - Otherwise, if `enable` = 1: count by ±1. If `enable` = 0: hold `cntout`.
  - The check is made before counting, so the counter never wraps.
- **DONE:** one cycle. Then go to IDLE; `gnt`, `done`, `timeout` -> 0. `cntout` holds its last value until the next LOAD.
- **Withdrawal:** if the granted `req[i]` is low in LOAD or RUN, go to IDLE on the next edge.
  - `gnt` is cleared and no `done` is produced.
  - Withdrawal takes priority over terminal detection on the same cycle.
  - Withdrawal is ignored in DONE.
- **Latched parameters:** `req_th` and `req_dn_up` changes after the grant have no effect until the next grant.
- **Re-grant:** a requester still high after `done` is eligible again. Round-robin order favours the other requesters first.
- **Threshold 0:** terminal is hit on the first RUN cycle, in either direction.

## Timing
- E0 is the edge at which IDLE samples the request.
- After E0: LOAD, `gnt` and `busy` high.
- After E0+1: RUN, `cntout` = start value.
- With `enable` held high, `done` and `timeout` are high after edge E0+TH+2, where TH is the latched threshold.
- After E0+TH+3: IDLE, `gnt` = 0.
- Each RUN cycle with `enable` = 0 adds one cycle to this latency.
- Back-to-back service: the next grant is issued at the edge after DONE→IDLE. The minimum gap between grants is one IDLE cycle.
- Asynchronous reset mid-operation aborts immediately: outputs are 0 without waiting for a clock, and no `done` is produced.

## Test plan
- **Single up request:** `req[1]`=1, th=5, up, `enable`=1. `gnt`=4'b0010 after E0; `cntout` steps 0..5; `done[1]`+`timeout` after E0+7; `gnt`=0 after E0+8.
- **Down mode with enable gaps:** th=12, down, `enable` low for 3 RUN cycles. `cntout` goes 12→0 with 3 hold cycles; `done` after E0+17.
- **Round robin:** `req`=4'b1111 held, all th=0. Grants are 0,1,2,3,0 in order, each 4 cycles apart (LOAD, RUN, DONE, IDLE).
- **Withdrawal:** `req[2]` dropped mid-RUN at `cntout`=3. Back to IDLE next edge; no `done`; a pending `req[3]` is granted the following cycle.
- **Parameter latch:** `req_th` changed 5→9 during RUN. Terminal stays at 5.
- **Reset mid-RUN:** `n_reset`=0 asynchronously. All outputs 0 immediately; after release the first grant goes to the lowest-index active requester.
